rans_multilane_renorm: RTL

Parametrised successor of the single-lane rANS state/pointer driver. Holds NUM_LANES interleaved rANS states and serves them round-robin to the symbol decoder. Renormalises each returned state with up to MAX_RENORM_BYTES input bytes and advances a shared byte pointer into the encoded file. Adds bounded-length operation, a symbol count, an underflow error and a done flag. Sits between the encoded-file memory (combinational read) and the rANS symbol decode datapath.

---
 rtl/rans_pkg.sv | 19 +
 rtl/rans_renorm_unit.sv | 31 +++
 rtl/rans_multilane_renorm.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rans_pkg.sv
// Shared types for the multi-lane rANS state driver: FSM encoding, renorm bound, lane index width.
// Latency: n/a (declarations only); backpressure: n/a.
package rans_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } rans_fsm_e;

  localparam logic [31:0] RENORM_MAX_DEF = 32'h0080_0000;

  // A single lane still needs a 1-bit select so the port never collapses to zero width.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rans_renorm_unit.sv
// Combinational renormalisation of one rANS state: shifts in bytes while state < RENORM_MAX.
// Latency: 0 cycles; backpressure: none, pure function of its inputs.
module rans_renorm_unit #(
  parameter int                 STATE_W          = 32,
  parameter logic [STATE_W-1:0] RENORM_MAX       = STATE_W'(32'h0080_0000),
  parameter int                 MAX_RENORM_BYTES = 3
) (
  input  logic [STATE_W-1:0]            state_in,
  input  logic [8*MAX_RENORM_BYTES-1:0] bytes_in,
  output logic [STATE_W-1:0]            state_out,
  output logic [2:0]                    n_bytes
);

  logic [STATE_W-1:0] s;
  logic [2:0]         n;

  // A state still below the bound after the last byte is passed through as is.
  always_comb begin
    s = state_in;
    n = '0;
    for (int k = 0; k < MAX_RENORM_BYTES; k++) begin
      if (s < RENORM_MAX) begin
        s = (s << 8) | STATE_W'(bytes_in[8*k +: 8]);
        n = n + 3'd1;
      end
    end
    state_out = s;
    n_bytes   = n;
  end

endmodule

// File: rtl/rans_multilane_renorm.sv
// Holds NUM_LANES interleaved rANS states, serves them round-robin and renormalises returned states.
// Latency: renormed result committed 1 cycle after acceptance; backpressure: none, one update per cycle in RUN.
module rans_multilane_renorm
  import rans_pkg::*;
#(
  parameter int                 NUM_LANES        = 2,
  parameter int                 STATE_W          = 32,
  parameter logic [STATE_W-1:0] RENORM_MAX       = STATE_W'(RENORM_MAX_DEF),
  parameter int                 MAX_RENORM_BYTES = 3,
  parameter int                 PTR_W            = 32,
  localparam int                LW               = lane_w(NUM_LANES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [PTR_W-1:0]              file_len,
  input  logic [PTR_W-1:0]              num_symbols,
  output logic [PTR_W-1:0]              enc_ptr,
  input  logic [8*MAX_RENORM_BYTES-1:0] enc_bytes,
  input  logic [STATE_W-1:0]            seed_word,
  output logic [LW-1:0]                 lane_sel,
  output logic [STATE_W-1:0]            state_out,
  output logic                          state_valid,
  input  logic [STATE_W-1:0]            new_state,
  input  logic                          new_state_valid,
  input  logic [7:0]                    sym_id,
  output logic [7:0]                    sym_out,
  output logic                          sym_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          underflow_err
);

  localparam int          SEED_BYTES = STATE_W / 8;
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

  rans_fsm_e          st, st_nxt;
  logic [STATE_W-1:0] lanes [NUM_LANES];
  logic [LW-1:0]      seed_cnt;
  logic [PTR_W-1:0]   count_q, file_len_q, num_sym_q;

  logic [STATE_W-1:0] rn_state;
  logic [2:0]         rn_n;
  logic [PTR_W:0]     seed_end, run_end;
  logic               seed_over, run_over;
  logic               seed_wr, accept, err_set;

  rans_renorm_unit #(
    .STATE_W         (STATE_W),
    .RENORM_MAX      (RENORM_MAX),
    .MAX_RENORM_BYTES(MAX_RENORM_BYTES)
  ) u_renorm (
    .state_in (new_state),
    .bytes_in (enc_bytes),
    .state_out(rn_state),
    .n_bytes  (rn_n)
  );

  // One extra bit so pointer + bytes never wraps before the length compare.
  assign seed_end  = {1'b0, enc_ptr} + (PTR_W+1)'(SEED_BYTES);
  assign run_end   = {1'b0, enc_ptr} + (PTR_W+1)'(rn_n);
  assign seed_over = seed_end > {1'b0, file_len_q};
  assign run_over  = run_end  > {1'b0, file_len_q};

  always_comb begin
    st_nxt  = st;
    seed_wr = 1'b0;
    accept  = 1'b0;
    err_set = 1'b0;
    case (st)
      ST_IDLE: ;
      ST_SEED: begin
        if (seed_over) begin
          err_set = 1'b1;
          st_nxt  = ST_DONE;
        end else begin
          seed_wr = 1'b1;
          if (seed_cnt == LAST_LANE) st_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (count_q == num_sym_q) begin
          st_nxt = ST_DONE;
        end else if (new_state_valid) begin
          if (run_over) begin
            err_set = 1'b1;
            st_nxt  = ST_DONE;
          end else begin
            accept = 1'b1;
            if (count_q + PTR_W'(1) == num_sym_q) st_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: ;
      default: st_nxt = ST_IDLE;
    endcase
    // Restart overrides everything, including a same-cycle update.
    if (start) begin
      st_nxt  = ST_SEED;
      seed_wr = 1'b0;
      accept  = 1'b0;
      err_set = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= ST_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_ptr       <= '0;
      lane_sel      <= '0;
      seed_cnt      <= '0;
      count_q       <= '0;
      file_len_q    <= '0;
      num_sym_q     <= '0;
      sym_out       <= '0;
      sym_valid     <= 1'b0;
      underflow_err <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) lanes[i] <= '0;
    end else begin
      sym_valid <= accept;
      if (start) begin
        enc_ptr       <= '0;
        lane_sel      <= '0;
        seed_cnt      <= '0;
        count_q       <= '0;
        underflow_err <= 1'b0;
        file_len_q    <= file_len;
        num_sym_q     <= num_symbols;
      end else begin
        if (err_set) underflow_err <= 1'b1;
        if (seed_wr) begin
          lanes[seed_cnt] <= seed_word;
          enc_ptr         <= enc_ptr + PTR_W'(SEED_BYTES);
          seed_cnt        <= seed_cnt + LW'(1);
        end
        if (accept) begin
          lanes[lane_sel] <= rn_state;
          enc_ptr         <= enc_ptr + PTR_W'(rn_n);
          lane_sel        <= (lane_sel == LAST_LANE) ? '0 : lane_sel + LW'(1);
          sym_out         <= sym_id;
          count_q         <= count_q + PTR_W'(1);
        end
      end
    end
  end

  assign state_out   = lanes[lane_sel];
  assign state_valid = (st == ST_RUN);
  assign busy        = (st == ST_SEED) || (st == ST_RUN);
  assign done        = (st == ST_DONE);

endmodule
